jk_sequence_driver: RTL and testbench

Stimulus/checker master for the JK flip-flop cell (`FF_JK`, ports clk, rst, enable, J, K, Q). Given a target bit pattern, it computes the JK excitation for each bit from the flip-flop's current Q, drives J/K/enable for one clock, then checks that Q reached the target. Mismatches are counted and a pass flag is reported. It is the driving end of the JK interface and is used for self-checking bring-up of the flip-flop in the lab designs.

---
 rtl/jk_sequence_driver.sv | 148 ++++++++++++++
 tb/tb_jk_sequence_driver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/jk_sequence_driver.sv
// Purpose : drives a JK flip-flop bit by bit toward a target pattern and checks that Q lands on each bit.
// Latency : 2 cycles per bit plus 1 DONE cycle (2*PATTERN_W+1 busy cycles); J/K/enable are registered.
// Backpr. : none; start is only honoured in IDLE, and start while busy is dropped.
module jk_sequence_driver #(
    parameter int PATTERN_W = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic                 Q,
    output logic                 J,
    output logic                 K,
    output logic                 enable,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     err_count,
    output logic                 pass
);

    localparam int IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATTERN_W - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PATTERN_W-1:0] pat_q, pat_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 j_q, j_d;
    logic                 k_q, k_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [CNT_W-1:0]     err_q, err_d;

    logic [IDX_W-1:0]     nxt_idx;
    logic                 nxt_t;
    logic [CNT_W-1:0]     err_next;

    // Next-state, excitation and scoreboard logic; excitation always uses the live Q.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        idx_d    = idx_q;
        j_d      = j_q;
        k_d      = k_q;
        en_d     = en_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        nxt_idx  = idx_q + IDX_W'(1);
        nxt_t    = pat_q[nxt_idx];
        err_next = err_q;
        if ((Q != pat_q[idx_q]) && (err_q != ERR_MAX)) begin
            err_next = err_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    idx_d   = '0;
                    // Hold when Q already equals the target, otherwise set or reset; never toggle.
                    j_d     = ~Q & pattern[0];
                    k_d     = Q & ~pattern[0];
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                j_d     = 1'b0;
                k_d     = 1'b0;
                en_d    = 1'b0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                err_d = err_next;
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    pass_d  = (err_next == '0);
                    state_d = S_DONE;
                end else begin
                    idx_d   = nxt_idx;
                    j_d     = ~Q & nxt_t;
                    k_d     = Q & ~nxt_t;
                    en_d    = 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset that overrides everything, mid-run included.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            j_q     <= j_d;
            k_q     <= k_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end
    end

    assign J         = j_q;
    assign K         = k_q;
    assign enable    = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_jk_sequence_driver.sv
// Bench for jk_sequence_driver: a JK flip-flop model closes the loop, expected J/K per bit
// and the final err_count/pass are queued when a run starts and popped as the DUT produces them.
module tb_jk_sequence_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic       Q;
    logic       J, K, enable, busy, done, pass;
    logic [7:0] err_count;

    logic       start2;
    logic [7:0] pattern2;
    logic       Q2;
    logic       J2, K2, enable2, busy2, done2, pass2;
    logic [1:0] err_count2;

    logic       q_ff;
    logic [1:0] mode;   // 0: working flip-flop, 1: Q stuck at 0, 2: Q stuck at 1

    int checks   = 0;
    int failures = 0;

    logic [1:0] jk_exp_q[$];
    logic [8:0] res_exp_q[$];

    always #5 clk = ~clk;

    jk_sequence_driver #(.PATTERN_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .Q(Q),
        .J(J), .K(K), .enable(enable), .busy(busy), .done(done),
        .err_count(err_count), .pass(pass)
    );

    jk_sequence_driver #(.PATTERN_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .pattern(pattern2), .Q(Q2),
        .J(J2), .K(K2), .enable(enable2), .busy(busy2), .done(done2),
        .err_count(err_count2), .pass(pass2)
    );

    // Behavioural FF_JK
    always @(posedge clk) begin
        if (rst) q_ff <= 1'b0;
        else if (enable) begin
            case ({J, K})
                2'b10:   q_ff <= 1'b1;
                2'b01:   q_ff <= 1'b0;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end

    assign Q = (mode == 2'd1) ? 1'b0 : (mode == 2'd2) ? 1'b1 : q_ff;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full run on dut: queue expectations, start, then watch 20 cycles.
    task automatic run(input logic [7:0] pat, input bit midrun, input string tag);
        logic       qq, qn, t, en_prev, pass_exp;
        int         exp_err, nbusy, ndone, done_cyc;
        logic [8:0] res;
        logic [1:0] jk;
        qq = Q; exp_err = 0; nbusy = 0; ndone = 0; done_cyc = -1; en_prev = 1'b0;
        pass_exp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            t = pat[i];
            jk_exp_q.push_back({~qq & t, qq & ~t});
            qn = (mode == 2'd1) ? 1'b0 : (mode == 2'd2) ? 1'b1 : t;
            if (qn != t) exp_err++;
            qq = qn;
        end
        res_exp_q.push_back({(exp_err == 0), 8'(exp_err)});
        @(negedge clk); pattern = pat; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (midrun && cyc == 5) begin start = 1'b1; pattern = ~pat; end
            if (midrun && cyc == 6) start = 1'b0;
            if (enable) begin
                if (jk_exp_q.size() == 0) check({tag, "_extra_drive"}, 1, 0);
                else begin
                    jk = jk_exp_q.pop_front();
                    check($sformatf("%s_jk_c%0d", tag, cyc), {30'd0, J, K}, {30'd0, jk});
                end
            end else begin
                check({tag, "_jk_off"}, {30'd0, J, K}, 0);
            end
            check({tag, "_en_twice"}, {31'd0, en_prev & enable}, 0);
            en_prev = enable;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                done_cyc = cyc;
                if (res_exp_q.size() == 0) check({tag, "_extra_done"}, 1, 0);
                else begin
                    res = res_exp_q.pop_front();
                    pass_exp = res[8];
                    check({tag, "_err"}, {24'd0, err_count}, {24'd0, res[7:0]});
                    check({tag, "_pass"}, {31'd0, pass}, {31'd0, res[8]});
                end
            end
            if (cyc == 18) begin
                check({tag, "_idle_busy"}, {31'd0, busy}, 0);
                check({tag, "_pass_hold"}, {31'd0, pass}, {31'd0, pass_exp});
            end
        end
        check({tag, "_done_cyc"}, done_cyc, 17);
        check({tag, "_busy_cycles"}, nbusy, 17);
        check({tag, "_done_count"}, ndone, 1);
        check({tag, "_jk_left"}, jk_exp_q.size(), 0);
        jk_exp_q.delete();
        res_exp_q.delete();
    endtask

    initial begin
        int ndone, dcyc;
        rst = 1'b1; start = 1'b0; pattern = 8'h00; mode = 2'd0;
        start2 = 1'b0; pattern2 = 8'h00; Q2 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outs", {26'd0, J, K, enable, busy, done, pass}, 0);
        check("rst_err", {24'd0, err_count}, 0);
        check("rst_err2", {30'd0, err_count2}, 0);
        rst = 1'b0;

        // Working flip-flop from Q=0
        run(8'b1011_0010, 1'b0, "basic");
        // Starts from Q=1 left by the previous run; excitation must follow the live Q
        run(8'b0000_1111, 1'b0, "liveq");
        // Q stuck at 0: set on every bit, every bit wrong
        mode = 2'd1;
        run(8'hFF, 1'b0, "stuck0");
        mode = 2'd0;
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
        // All-zero pattern from Q=0 with a stray start and pattern change mid-run
        run(8'h00, 1'b1, "zero_mid");

        // Reset in the CHECK cycle of bit 3
        @(negedge clk); pattern = 8'b1011_0010; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_in_check", {30'd0, busy, enable}, 32'h2);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outs", {26'd0, J, K, enable, busy, done, pass}, 0);
        check("abort_err", {24'd0, err_count}, 0);
        rst = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run(8'b1011_0010, 1'b0, "after_rst");

        // Narrow counter: Q stuck at 1, all-zero pattern, count saturates at 3
        @(negedge clk); start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        dcyc = -1;
        for (int cyc = 1; cyc <= 40 && dcyc < 0; cyc++) begin
            @(negedge clk);
            if (done2) dcyc = cyc;
        end
        check("sat_done_cyc", dcyc, 17);
        check("sat_err", {30'd0, err_count2}, 3);
        check("sat_pass", {31'd0, pass2}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
